crc_frame_seq: RTL

//  Frame sequencer around the combinational crc_module (CRC-16, poly 1+x^5+x^12+x^16).
//  - Accepts 16-bit words on a valid/ready input stream and forwards them through a one-entry output register.
//  - Accumulates the running CRC in a state register.
//  - After the word flagged s_last, appends the CRC word as the closing beat.
//  - Sits between the packet source and the link serializer.

---
 rtl/crc_frame_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/crc_frame_seq.sv
// -----------------------------------------------------------------------------
// crc_frame_seq
//   Frame sequencer between the packet source and the link serializer.
//   Payload words arrive on a valid/ready stream and are forwarded through a
//   one-entry output register while a running CRC-16 (poly 0x1021,
//   1+x^5+x^12+x^16, MSB-first, one 16-bit word per step) accumulates. After
//   the word flagged s_last, or once MAX_WORDS words have been taken, the CRC
//   is appended as the closing beat of the frame.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   clr        in   1      synchronous abort: drop frame, back to IDLE
//   s_valid    in   1      input word valid
//   s_ready    out  1      block can accept input word
//   s_data     in   16     input word
//   s_last     in   1      last payload word of the frame
//   m_valid    out  1      output beat valid
//   m_ready    in   1      downstream accepts beat
//   m_data     out  16     payload word or CRC word
//   m_last     out  1      final beat of the frame (the CRC beat)
//   m_is_crc   out  1      beat carries the CRC
//   frame_len  out  LEN_W  payload words of the last completed frame
//   len_err    out  1      one-cycle pulse: frame forced closed at MAX_WORDS
//   chk_done   out  1      (CRC_CHECK_EN only) pulse one cycle after frame end
//   chk_err    out  1      (CRC_CHECK_EN only) nonzero residue, valid with chk_done
//
// Configuration macro: CRC_CHECK_EN adds the chk_done / chk_err residue check.
// -----------------------------------------------------------------------------
module crc_frame_seq #(
    parameter logic [15:0] CRC_INIT  = 16'h0000,
    parameter int          MAX_WORDS = 256,
    parameter int          LEN_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [15:0]      s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [15:0]      m_data,
    output logic             m_last,
    output logic             m_is_crc,
    output logic [LEN_W-1:0] frame_len,
    output logic             len_err
`ifdef CRC_CHECK_EN
    ,
    output logic             chk_done,
    output logic             chk_err
`endif
);

    localparam logic [15:0]      CRC_POLY = 16'h1021;
    localparam logic [LEN_W-1:0] MAX_CNT  = LEN_W'(MAX_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2
    } state_t;

    // One CRC-16 step over a full 16-bit word, data MSB first.
    function automatic logic [15:0] crc_module(input logic [15:0] data,
                                               input logic [15:0] crc_in);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

    state_t           r_state;
    logic [15:0]      r_crc;
    logic [LEN_W-1:0] r_word_cnt;
    logic             r_m_valid;
    logic [15:0]      r_m_data;
    logic             r_m_last;
    logic             r_m_is_crc;
    logic [LEN_W-1:0] r_frame_len;
    logic             r_len_err;

    logic             w_slot_free;
    logic             w_acc;
    logic [LEN_W-1:0] w_cnt_inc;
    logic             w_at_max;
    logic             w_frame_end;
    logic [15:0]      w_crc_next;

    assign w_slot_free = !r_m_valid || m_ready;
    assign s_ready     = w_slot_free && (r_state != ST_CRC);
    assign w_acc       = s_valid && s_ready;
    assign w_cnt_inc   = r_word_cnt + LEN_W'(1);
    assign w_at_max    = (w_cnt_inc == MAX_CNT);
    assign w_frame_end = s_last || w_at_max;
    assign w_crc_next  = crc_module(s_data, r_crc);

    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_last    = r_m_last;
    assign m_is_crc  = r_m_is_crc;
    assign frame_len = r_frame_len;
    assign len_err   = r_len_err;

    // Frame FSM, CRC accumulator, word counter and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_crc       <= CRC_INIT;
            r_word_cnt  <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= 16'h0000;
            r_m_last    <= 1'b0;
            r_m_is_crc  <= 1'b0;
            r_frame_len <= '0;
            r_len_err   <= 1'b0;
        end else if (clr) begin
            // Abort takes priority over any accept; last frame_len is kept.
            r_state    <= ST_IDLE;
            r_crc      <= CRC_INIT;
            r_word_cnt <= '0;
            r_m_valid  <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            r_len_err <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DATA: begin
                    if (w_acc) begin
                        r_m_data   <= s_data;
                        r_m_valid  <= 1'b1;
                        r_m_last   <= 1'b0;
                        r_m_is_crc <= 1'b0;
                        r_crc      <= w_crc_next;
                        r_word_cnt <= w_cnt_inc;
                        if (w_frame_end) begin
                            r_state   <= ST_CRC;
                            // Only a size-forced close is an error.
                            r_len_err <= !s_last;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end else if (r_m_valid && m_ready) begin
                        r_m_valid <= 1'b0;
                    end
                end
                ST_CRC: begin
                    if (w_slot_free) begin
                        r_m_data    <= r_crc;
                        r_m_valid   <= 1'b1;
                        r_m_last    <= 1'b1;
                        r_m_is_crc  <= 1'b1;
                        r_frame_len <= r_word_cnt;
                        r_crc       <= CRC_INIT;
                        r_word_cnt  <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef CRC_CHECK_EN
    logic r_chk_done;
    logic r_chk_err;

    assign chk_done = r_chk_done;
    assign chk_err  = r_chk_err;

    // Residue over payload plus received tail; zero means the tail matched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk_done <= 1'b0;
            r_chk_err  <= 1'b0;
        end else if (clr) begin
            r_chk_done <= 1'b0;
            r_chk_err  <= 1'b0;
        end else if (w_acc && w_frame_end) begin
            r_chk_done <= 1'b1;
            r_chk_err  <= (w_crc_next != 16'h0000);
        end else begin
            r_chk_done <= 1'b0;
            r_chk_err  <= 1'b0;
        end
    end
`else
    // Residue checker not built in this configuration.
`endif

endmodule
